// File: rtl/sgf_mult_pkg.sv
// Shared width helpers and pipeline constants for the significand multiplier,
// used by the multiplier pipe and the downstream normaliser/rounder.
package sgf_mult_pkg;

    localparam int LATENCY = 3;

    function automatic int sgf_hi_w(input int sw);
        return sw / 2;
    endfunction

    function automatic int sgf_lo_w(input int sw);
        return sw - sw / 2;
    endfunction

endpackage

// File: rtl/sgf_mult_pipe_reg.sv
// Enable/clear register with asynchronous active-low reset; every pipeline
// stage's data and valid bits are held in one of these.
module sgf_mult_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over enable so a flush can drop valid bits during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sgf_mult_pipe.sv
// Three-stage Karatsuba significand multiplier with valid/ready flow control.
// Define SGF_MULT_NORM_EN to add the registered norm_shift_o / sticky_o outputs.
module sgf_mult_pipe
    import sgf_mult_pkg::*;
#(
    parameter int SW = 54
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2*SW-1:0] sgf_result_o,
    output logic            busy_o
`ifdef SGF_MULT_NORM_EN
    ,
    output logic            norm_shift_o,
    output logic            sticky_o
`endif
);

    localparam int HI_W  = sgf_hi_w(SW);
    localparam int LO_W  = sgf_lo_w(SW);
    localparam int SUM_W = LO_W + 1;
    localparam int PM_W  = 2 * LO_W + 2;
    localparam int RW    = 2 * SW + 2;
    localparam int S0_W  = 2 * HI_W + 2 * LO_W + 2 * SUM_W;
    localparam int S1_W  = 2 * HI_W + 2 * LO_W + PM_W;
`ifdef SGF_MULT_NORM_EN
    localparam int S2_W  = 2 * SW + 2;
`else
    localparam int S2_W  = 2 * SW;
`endif

    // Handshake: the whole pipe advances together whenever the output slot
    // is empty or being consumed; in_ready_o additionally drops during flush.
    logic       adv;
    logic       data_en;
    logic [2:0] vld_d;
    logic [2:0] vld_q;

    assign adv         = ~vld_q[2] | out_ready_i;
    assign data_en     = adv & ~flush_i;
    assign in_ready_o  = adv & ~flush_i;
    assign out_valid_o = vld_q[2];
    assign busy_o      = |vld_q;
    assign vld_d       = {vld_q[1:0], in_valid_i};

    sgf_mult_pipe_reg #(.W(3)) u_vld (
        .clk (clk), .rst (rst), .en (adv), .clr (flush_i), .d (vld_d), .q (vld_q)
    );

    // Stage 0: operand halves and half-sums.
    logic [HI_W-1:0]  a_hi, b_hi, s0_a_hi, s0_b_hi;
    logic [LO_W-1:0]  a_lo, b_lo, s0_a_lo, s0_b_lo;
    logic [SUM_W-1:0] sa, sb, s0_sa, s0_sb;
    logic [S0_W-1:0]  s0_q;

    assign a_hi = Data_A_i[SW-1:LO_W];
    assign a_lo = Data_A_i[LO_W-1:0];
    assign b_hi = Data_B_i[SW-1:LO_W];
    assign b_lo = Data_B_i[LO_W-1:0];
    assign sa   = SUM_W'(a_hi) + SUM_W'(a_lo);
    assign sb   = SUM_W'(b_hi) + SUM_W'(b_lo);

    sgf_mult_pipe_reg #(.W(S0_W)) u_s0 (
        .clk (clk), .rst (rst), .en (data_en), .clr (1'b0),
        .d   ({a_hi, a_lo, b_hi, b_lo, sa, sb}), .q (s0_q)
    );
    assign {s0_a_hi, s0_a_lo, s0_b_hi, s0_b_lo, s0_sa, s0_sb} = s0_q;

    // Stage 1: the three Karatsuba sub-products.
    logic [2*HI_W-1:0] ph, s1_ph;
    logic [2*LO_W-1:0] pl, s1_pl;
    logic [PM_W-1:0]   pm, s1_pm;
    logic [S1_W-1:0]   s1_q;

    assign ph = (2 * HI_W)'(s0_a_hi) * (2 * HI_W)'(s0_b_hi);
    assign pl = (2 * LO_W)'(s0_a_lo) * (2 * LO_W)'(s0_b_lo);
    assign pm = PM_W'(s0_sa) * PM_W'(s0_sb);

    sgf_mult_pipe_reg #(.W(S1_W)) u_s1 (
        .clk (clk), .rst (rst), .en (data_en), .clr (1'b0),
        .d   ({ph, pl, pm}), .q (s1_q)
    );
    assign {s1_ph, s1_pl, s1_pm} = s1_q;

    // Stage 2: recombine at full width; the top two bits are always zero, so
    // truncating to 2*SW is exact, and PM >= PH + PL keeps the middle term positive.
    logic [2*SW-1:0] r;
    logic [S2_W-1:0] s2_d;
    logic [S2_W-1:0] s2_q;

    assign r = (2 * SW)'((RW'(s1_ph) << (2 * LO_W))
                       + ((RW'(s1_pm) - RW'(s1_ph) - RW'(s1_pl)) << LO_W)
                       + RW'(s1_pl));

`ifdef SGF_MULT_NORM_EN
    logic norm;
    logic sticky;

    assign norm   = r[2*SW-1];
    assign sticky = norm ? |r[SW-3:0] : |r[SW-4:0];
    assign s2_d   = {norm, sticky, r};
`else
    assign s2_d   = r;
`endif

    sgf_mult_pipe_reg #(.W(S2_W)) u_s2 (
        .clk (clk), .rst (rst), .en (data_en), .clr (1'b0), .d (s2_d), .q (s2_q)
    );

`ifdef SGF_MULT_NORM_EN
    assign {norm_shift_o, sticky_o, sgf_result_o} = s2_q;
`else
    assign sgf_result_o = s2_q;
`endif

endmodule

// File: tb/tb_sgf_mult_pipe.sv
// Self-checking bench for sgf_mult_pipe: SW=24 instance checked every cycle
// against a queue model, plus an odd-width SW=53 instance with directed vectors.
module tb_sgf_mult_pipe;

    localparam int SW  = 24;
    localparam int SW2 = 53;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (SW=24) ----------------
    logic            flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [SW-1:0]   a, b;
    logic [2*SW-1:0] res;
`ifdef SGF_MULT_NORM_EN
    logic            norm_shift, sticky;
`endif

    sgf_mult_pipe #(.SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .Data_A_i     (a),
        .Data_B_i     (b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .sgf_result_o (res),
        .busy_o       (busy)
`ifdef SGF_MULT_NORM_EN
        ,
        .norm_shift_o (norm_shift),
        .sticky_o     (sticky)
`endif
    );

    // ---------------- DUT (SW=53, odd split) ----------------
    logic             flush2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [SW2-1:0]   a2, b2;
    logic [2*SW2-1:0] res2;
`ifdef SGF_MULT_NORM_EN
    logic             norm_shift2, sticky2;
`endif

    sgf_mult_pipe #(.SW(SW2)) dut53 (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush2),
        .in_valid_i   (in_valid2),
        .in_ready_o   (in_ready2),
        .Data_A_i     (a2),
        .Data_B_i     (b2),
        .out_valid_o  (out_valid2),
        .out_ready_i  (out_ready2),
        .sgf_result_o (res2),
        .busy_o       (busy2)
`ifdef SGF_MULT_NORM_EN
        ,
        .norm_shift_o (norm_shift2),
        .sticky_o     (sticky2)
`endif
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [2*SW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*SW-1:0] mul24(input logic [SW-1:0] x, input logic [SW-1:0] y);
        return (2 * SW)'(x) * (2 * SW)'(y);
    endfunction

    // Model: ordered list of accepted-but-unconsumed products. Consumption
    // pops the head; flush drops whatever was not consumed that cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            chk("busy_vs_model", busy, exp_q.size() != 0);
            if (out_valid) begin
                chk("valid_has_pending_op", exp_q.size() != 0, 1'b1);
                if (out_ready && exp_q.size() != 0)
                    chk("result_in_order", res, exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            if (in_valid && in_ready) begin
                if (flush) chk("accept_during_flush", 1'b1, 1'b0);
                exp_q.push_back(mul24(a, b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op with out_ready held high; checks latency and a literal product.
    task automatic run_one(input logic [SW-1:0] x, input logic [SW-1:0] y,
                           input logic [2*SW-1:0] exp, input string name);
        int edges;
        out_ready = 1'b1;
        a = x; b = y; in_valid = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            step();
            edges++;
        end
        chk({name, "_latency"}, edges, 3);
        chk({name, "_value"}, res, exp);
    endtask

    task automatic run53(input logic [SW2-1:0] x, input logic [SW2-1:0] y,
                         input logic [2*SW2-1:0] exp, input string name);
        int edges;
        a2 = x; b2 = y; in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        edges = 1;
        while (!out_valid2 && edges < 10) begin
            step();
            edges++;
        end
        chk({name, "_latency"}, edges, 3);
        chk({name, "_value"}, res2, exp);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk({name, "_drained"}, busy, 1'b0);
        chk({name, "_model_empty"}, exp_q.size(), 0);
    endtask

    logic [SW-1:0] fa[3];
    logic [SW-1:0] fb[3];

    task automatic fill3(input logic rdy);
        out_ready = rdy;
        for (int i = 0; i < 3; i++) begin
            fa[i] = SW'($urandom_range(1, 32'hFFFFFF));
            fb[i] = SW'($urandom_range(1, 32'hFFFFFF));
            a = fa[i]; b = fb[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [2*SW2-1:0] p104;
    int n_acc, guard;

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", res, '0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Directed literal products
        run_one(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "all_ones");
`ifdef SGF_MULT_NORM_EN
        chk("all_ones_norm", norm_shift, 1'b1);
        chk("all_ones_sticky", sticky, 1'b1);
`endif
        run_one(24'h800000, 24'h800000, 48'h400000000000, "msb_sq");
`ifdef SGF_MULT_NORM_EN
        chk("msb_sq_norm", norm_shift, 1'b0);
        chk("msb_sq_sticky", sticky, 1'b0);
`endif
        run_one(24'hABCDEF, 24'h000010, 48'h00000ABCDEF0, "shift4");
        run_one(24'h000000, 24'h5A5A5A, 48'h000000000000, "zero_a");
        run_one(24'h123456, 24'h000002, 48'h0000002468AC, "times2");

        // Odd width split
        p104 = '0;
        p104[104] = 1'b1;
        run53(53'h10000000000000, 53'h10000000000000, p104, "sw53_pow");
        run53(53'h0, 53'h1F0F0F0F0F0F0F, '0, "sw53_zero");
        run53(53'h1FFFFFFFFFFFFF, 53'h1, 106'h1FFFFFFFFFFFFF, "sw53_one");
        wait_idle("directed");

        // Back-to-back random stream with random back-pressure
        n_acc = 0;
        guard = 0;
        while (n_acc < 100 && guard < 2000) begin
            a = SW'($urandom());
            b = SW'($urandom());
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) n_acc++;
            step();
            guard++;
        end
        chk("random_all_accepted", n_acc, 100);
        wait_idle("random");

        // Full-pipe stall: outputs frozen, no acceptance, then in-order drain
        fill3(1'b0);
        a = 24'h0F0F0F; b = 24'h0F0F0F; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_result", res, mul24(fa[0], fb[0]));
            step();
        end
        in_valid = 1'b0;
        wait_idle("stall");

        // Flush with three in flight; head is consumed in the flush cycle
        fill3(1'b1);
        flush = 1'b1; in_valid = 1'b1; a = 24'h00FF00; b = 24'h000003;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_late_valid", out_valid, 1'b0);
        end

        // Asynchronous reset mid-stream
        fill3(1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", res, '0);
        chk("midrst_busy", busy, 1'b0);
        step();
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_valid", out_valid, 1'b0);
        end

        // Pipeline still healthy after reset
        run_one(24'h000101, 24'h000101, 48'h000000010201, "after_rst");
        wait_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
